// File: rtl/ram_port_arbiter_if.sv
// Requester-side command/response bundle for the RAM port arbiter.
// Signals: req/we/addr/wdata/lock (command), gnt/rvalid/rdata (response).
interface ram_port_arbiter_if #(
   parameter int AW = 12,
   parameter int DW = 16
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          lock;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, wdata, lock,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, lock,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one sync RAM between CPU and I/O.
// Ports: clk, rst (async high), cpu/io requester ifs, mem_* RAM pins.
module ram_port_arbiter #(
   parameter int AW = 12,
   parameter int DW = 16
) (
   input  logic              clk,
   input  logic              rst,
   ram_port_arbiter_if.slave cpu,
   ram_port_arbiter_if.slave io,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata
);

   localparam logic [1:0] ARB      = 2'd0;
   localparam logic [1:0] LOCK_CPU = 2'd1;
   localparam logic [1:0] LOCK_IO  = 2'd2;

   logic [1:0]    state_q, state_d;
   // last winner: 0 = CPU, 1 = I/O
   logic          last_q, last_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   // read pending pipe: {valid, owner}, owner 1 = I/O
   logic          p1v_q, p1v_d;
   logic          p1o_q, p1o_d;
   logic          p2v_q, p2o_q;
   logic          sel_cpu, sel_io;

   always_comb begin
      sel_cpu = 1'b0;
      sel_io  = 1'b0;
      unique case (state_q)
         LOCK_CPU: sel_cpu = 1'b1;
         LOCK_IO:  sel_io  = 1'b1;
         default: begin
            sel_cpu = cpu.req & (~io.req | last_q);
            sel_io  = io.req & ~sel_cpu;
         end
      endcase
   end

   // rst masks grants so nothing transfers while held in reset
   assign cpu.gnt = cpu.req & sel_cpu & ~rst;
   assign io.gnt  = io.req & sel_io & ~rst;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      p1v_d   = 1'b0;
      p1o_d   = 1'b0;
      if (cpu.gnt) begin
         state_d = cpu.lock ? LOCK_CPU : ARB;
         last_d  = 1'b0;
         we_d    = cpu.we;
         addr_d  = cpu.addr;
         wdata_d = cpu.wdata;
         p1v_d   = ~cpu.we;
      end else if (io.gnt) begin
         state_d = io.lock ? LOCK_IO : ARB;
         last_d  = 1'b1;
         we_d    = io.we;
         addr_d  = io.addr;
         wdata_d = io.wdata;
         p1v_d   = ~io.we;
         p1o_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         p1v_q   <= 1'b0;
         p1o_q   <= 1'b0;
         p2v_q   <= 1'b0;
         p2o_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         p1v_q   <= p1v_d;
         p1o_q   <= p1o_d;
         p2v_q   <= p1v_q;
         p2o_q   <= p1o_q;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign cpu.rvalid = p2v_q & ~p2o_q;
   assign io.rvalid  = p2v_q & p2o_q;
   assign cpu.rdata  = mem_rdata;
   assign io.rdata   = mem_rdata;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the single-port 4096x16 synchronous RAM. It shares the RAM between the CPU control unit (fetch, operand read, STA/BSA/ISZ writes) and the I/O side (INPR/OUTR transfer engine). Arbitration is round-robin, with a lock for indivisible read-modify-write sequences such as ISZ. The block sits between both requesters and the RAM's `we`/`read_address`/`write_address`/`data_in`/`data_out` pins.

## Interface
- `AW`, default 12: address width (4096 words).
- `DW`, default 16: data width.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cpu_req`  in  1  CPU command valid; hold `cpu_we`, `cpu_addr`, `cpu_wdata` and `cpu_lock` stable until granted.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  word address.
- `cpu_wdata`  in  DW  write data.
- `cpu_lock`  in  1  keep ownership after this access.
- `cpu_gnt`  out  1  command accepted this cycle (combinational).
- `cpu_rvalid`  out  1  read data for the CPU is valid this cycle.
- `cpu_rdata`  out  DW  read data; meaningful only when `cpu_rvalid` is 1.
- `io_req`, `io_we`, `io_addr`, `io_wdata`, `io_lock`, `io_gnt`, `io_rvalid`, `io_rdata`: identical to the `cpu_*` set, for the I/O requester.
- `mem_we`  out  1  RAM write enable (registered).
- `mem_addr`  out  AW  RAM address, driven to both read and write address pins (registered).
- `mem_wdata`  out  DW  RAM write data (registered).
- `mem_rdata`  in  DW  RAM `data_out`; registered inside the RAM, valid one cycle after the address.

## Operation
- Handshake: an access transfers at a rising edge where `x_req` = 1 and `x_gnt` = 1. At most one transfer per cycle. After its own transfer, a requester may present a new command in the next cycle.
- Grant rules: `x_gnt` = `x_req` AND (x is the selected winner). `gnt` never depends on `rdata`.
- Arbitration FSM, states ARB, LOCK_CPU, LOCK_IO:
  - ARB, one requester: that requester wins.
  - ARB, both requesting: the requester that is not `last` wins. `last` is a 1-bit pointer, updated to the winner on every transfer.
  - Transfer with `x_lock` = 1: go to LOCK_x.
  - LOCK_x: only x can be granted; the other requester's `gnt` = 0 even if x is idle.
  - Transfer by x with `x_lock` = 0: return to ARB, with `last` = x.
- Transfer action, on the transfer edge: `mem_addr`, `mem_we` and `mem_wdata` are loaded from the winner.
- Idle cycles (no transfer): `mem_we` = 0; `mem_addr` and `mem_wdata` hold their values.
- Read tracking: a two-stage pending pipeline, each stage holding {valid, owner}.
  - Stage 1 is loaded on a read transfer and cleared on a write transfer or idle cycle.
  - Stage 2 takes stage 1 each cycle.
  - `x_rvalid` = stage2.valid AND (stage2.owner == x).
- `cpu_rdata` = `io_rdata` = `mem_rdata` (broadcast); qualify with `rvalid`.
- Writes produce no response.
- Addresses are used as given, with no wrap or range logic; the full 0..4095 range is legal.

## Timing
- Reset values: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_gnt` = `io_gnt` = 0 while `rst` = 1, `cpu_rvalid` = `io_rvalid` = 0, pipeline empty, state ARB, `last` = I/O (so the CPU wins the first contention).
- Read latency: transfer at edge E, `mem_addr` valid after E, RAM samples at E+1, `x_rvalid` = 1 and data valid in the cycle after E+1. That is 2 cycles from transfer to data.
- Write: `mem_we` is high for exactly the one cycle after the transfer; the RAM commits the write at the following edge.
- Throughput: one access per cycle, sustained back-to-back, with reads fully pipelined.
- Read-after-write to the same address in consecutive transfers returns the new data; no hazard logic is required.
- Simultaneous requests in ARB are alternated strictly; neither requester waits more than one transfer while the other holds no lock.
- Reset mid-operation: in-flight reads are dropped (no `rvalid` is produced after reset), any lock is released, and no spurious `mem_we` occurs.

## Test plan
- Reset release, then `cpu_req` read at address 0x001 with RAM[1] = 0x2015 -> `cpu_gnt` = 1 the same cycle, `mem_addr` = 0x001 the next cycle, `cpu_rvalid` = 1 with `cpu_rdata` = 0x2015 two cycles after the transfer; `io_rvalid` stays 0.
- Both requesters issue continuous reads of addresses 0x014 (CPU) and 0x015 (I/O) -> grants go CPU, I/O, CPU, I/O…; the `rvalid` owners follow the same order 2 cycles later, returning 0x000F and 0x000B.
- CPU ISZ sequence on 0x013 with RAM = 0xFFF8: read with lock=1, then write 0xFFF9 with lock=0, while `io_req` is held -> `io_gnt` = 0 until the write transfers, then `io_gnt` = 1.
- CPU write of 0x1234 to 0x016, immediately followed by a CPU read of 0x016 -> `mem_we` pulses for one cycle and the read returns 0x1234.
- Read transfer, then `rst` asserted asynchronously one cycle later -> `rvalid` never asserts, `mem_we` = 0, `mem_addr` = 0; after release the CPU wins the first contention.
- Idle cycles between accesses -> `mem_we` = 0 and `mem_addr` holds its last value.
